// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add / restoring divide, fixed 33-cycle latency.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic            KILL,
    input  logic [4:0]      ALUOP,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    output logic [XLEN-1:0] RESULT,
    output logic            BUSY,
    output logic            DONE
);

    localparam logic [4:0] OP_MUL    = 5'b01001;
    localparam logic [4:0] OP_MULH   = 5'b01010;
    localparam logic [4:0] OP_MULHU  = 5'b01011;
    localparam logic [4:0] OP_MULHSU = 5'b01100;
    localparam logic [4:0] OP_DIV    = 5'b01101;
    localparam logic [4:0] OP_DIVU   = 5'b01110;
    localparam logic [4:0] OP_REM    = 5'b01111;
    localparam logic [4:0] OP_REMU   = 5'b10000;

    localparam logic [XLEN-1:0]  SMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN-1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t            state;
    logic [4:0]        op;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   d1;
    logic              neg;
    logic              dz;
    logic              ovf;
    logic [CNT_W-1:0]  cnt;

    logic              in_valid;
    logic              in_mul;
    logic              a_neg;
    logic              b_neg;
    logic              in_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;

    always_comb begin
        in_valid = (ALUOP >= OP_MUL) && (ALUOP <= OP_REMU);
        in_mul   = (ALUOP <= OP_MULHSU);
        a_neg    = DATA1[XLEN-1] &&
                   (ALUOP inside {OP_MUL, OP_MULH, OP_MULHSU,
                                  OP_DIV, OP_REM});
        b_neg    = DATA2[XLEN-1] &&
                   (ALUOP inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
        a_mag    = a_neg ? -DATA1 : DATA1;
        b_mag    = b_neg ? -DATA2 : DATA2;
        // Remainder follows the dividend; everything else uses xor.
        in_neg   = (ALUOP == OP_REM) ? a_neg : (a_neg ^ b_neg);
    end

    logic              is_mul;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] sh;
    logic              fits;
    logic [2*XLEN-1:0] step;

    assign is_mul = (op <= OP_MULHSU);

    // acc = {hi, lo}: product accumulator, or {remainder, quotient}.
    always_comb begin
        sum  = {1'b0, acc[2*XLEN-1:XLEN]} +
               (acc[0] ? {1'b0, opb} : '0);
        sh   = {acc[2*XLEN-2:0], 1'b0};
        fits = acc[2*XLEN-1] | (sh[2*XLEN-1:XLEN] >= opb);
        if (is_mul) begin
            step = {sum, acc[XLEN-1:1]};
        end else if (fits) begin
            step = {sh[2*XLEN-1:XLEN] - opb, sh[XLEN-1:1], 1'b1};
        end else begin
            step = sh;
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   res;

    always_comb begin
        prod = neg ? -acc : acc;
        quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        unique case (1'b1)
            op == OP_MUL: begin
                res = prod[XLEN-1:0];
            end
            op inside {OP_MULH, OP_MULHU, OP_MULHSU}: begin
                res = prod[2*XLEN-1:XLEN];
            end
            op inside {OP_DIV, OP_DIVU}: begin
                res = dz ? '1 : (ovf ? SMIN : quo);
            end
            op inside {OP_REM, OP_REMU}: begin
                res = dz ? d1 : (ovf ? '0 : rem);
            end
            default: begin
                res = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state  <= IDLE;
            op     <= '0;
            acc    <= '0;
            opb    <= '0;
            d1     <= '0;
            neg    <= 1'b0;
            dz     <= 1'b0;
            ovf    <= 1'b0;
            cnt    <= '0;
            RESULT <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (START && !KILL && in_valid) begin
                        op    <= ALUOP;
                        d1    <= DATA1;
                        neg   <= in_neg;
                        dz    <= (DATA2 == '0);
                        ovf   <= (ALUOP inside {OP_DIV, OP_REM}) &&
                                 (DATA1 == SMIN) && (DATA2 == '1);
                        acc   <= {{XLEN{1'b0}}, in_mul ? b_mag : a_mag};
                        opb   <= in_mul ? a_mag : b_mag;
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (KILL) begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc <= step;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                    if (!KILL) begin
                        RESULT <= res;
                        DONE   <= 1'b1;
                    end
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
